// File: rtl/div_share_arbiter_pkg.sv
// Shared definitions for the divider-sharing arbiter: FSM encoding, default width,
// and the quotient returned for a zero divisor.
package div_share_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_GRANT = ST_GRANT,
      S_WAIT  = ST_WAIT,
      S_RESP  = ST_RESP
   } state_t;

   localparam int DEF_DW = 4;

   // All-ones quotient for divide-by-zero; sliced to DW at the use site.
   localparam logic [31:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_share_arbiter_if.sv
// Requester and divider signal bundle for div_share_arbiter.
// slave = arbiter side, master = requesters plus divider.
interface div_share_arbiter_if
   import div_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DW      = DEF_DW
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*DW-1:0] dividend_in;
   logic [NUM_REQ*DW-1:0] divisor_in;
   logic [NUM_REQ-1:0]    gnt;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [DW-1:0]         rsp_quotient;
   logic [DW-1:0]         rsp_remainder;
   logic                  rsp_err;
   logic                  busy;
   logic                  div_start;
   logic [DW-1:0]         div_dividend;
   logic [DW-1:0]         div_divisor;
   logic                  div_done;
   logic [DW-1:0]         div_quotient;
   logic [DW-1:0]         div_remainder;

   modport slave (
      input  req, dividend_in, divisor_in, div_done, div_quotient, div_remainder,
      output gnt, rsp_valid, rsp_quotient, rsp_remainder, rsp_err, busy,
             div_start, div_dividend, div_divisor
   );

   modport master (
      output req, dividend_in, divisor_in, div_done, div_quotient, div_remainder,
      input  gnt, rsp_valid, rsp_quotient, rsp_remainder, rsp_err, busy,
             div_start, div_dividend, div_divisor
   );
endinterface

// File: rtl/div_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping
// past N-1 back to 0.
module div_share_arbiter_rr_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
)(
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);
   logic [IW:0] w_pos;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      w_pos    = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = {1'b0, i_ptr} + (IW+1)'(k);
         if (w_pos >= (IW+1)'(N))
            w_pos = w_pos - (IW+1)'(N);
         if (!o_any && i_req[w_pos[IW-1:0]]) begin
            o_any                   = 1'b1;
            o_idx                   = w_pos[IW-1:0];
            o_onehot[w_pos[IW-1:0]] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/div_share_arbiter.sv
// Shares one multi-cycle divider among NUM_REQ requesters: round-robin grant, start
// sequencing, result capture, divide-by-zero short-circuit and hung-divider timeout.
module div_share_arbiter
   import div_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DW      = DEF_DW,
   parameter int TIMEOUT = 31
)(
   input logic                i_clk,
   input logic                i_reset,
   div_share_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t             r_state, w_state_nxt;
   logic [IW-1:0]      r_owner, r_ptr, w_pick_idx;
   logic [NUM_REQ-1:0] r_owner_oh, w_pick_oh;
   logic               w_pick_any;
   logic [DW-1:0]      r_dvd, r_dvs, r_q, r_r;
   logic               r_err;
   logic [CW-1:0]      r_cnt;
   logic               w_tmo;
   logic [NUM_REQ-1:0] w_gnt, w_rsp_vld;
   logic               w_start;

   div_share_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
      .i_req    (bus.req),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx),
      .o_any    (w_pick_any)
   );

   // Last WAIT cycle allowed before forcing an error response.
   assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt       = '0;
      w_rsp_vld   = '0;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE:  if (w_pick_any) w_state_nxt = S_GRANT;
         S_GRANT: begin
            w_gnt       = r_owner_oh;
            w_start     = (r_dvs != '0);
            w_state_nxt = (r_dvs == '0) ? S_RESP : S_WAIT;
         end
         S_WAIT:  if (bus.div_done || w_tmo) w_state_nxt = S_RESP;
         S_RESP: begin
            w_rsp_vld   = r_owner_oh;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operands are latched on the IDLE->GRANT edge so they are already on div_* while
   // div_start is high.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_owner    <= '0;
         r_owner_oh <= '0;
         r_ptr      <= '0;
         r_dvd      <= '0;
         r_dvs      <= '0;
         r_q        <= '0;
         r_r        <= '0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_pick_any) begin
               r_owner    <= w_pick_idx;
               r_owner_oh <= w_pick_oh;
               r_dvd      <= bus.dividend_in[w_pick_idx*DW +: DW];
               r_dvs      <= bus.divisor_in[w_pick_idx*DW +: DW];
            end
            S_GRANT: begin
               r_cnt <= '0;
               if (r_dvs == '0) begin
                  r_q   <= DIV0_QUOT[DW-1:0];
                  r_r   <= r_dvd;
                  r_err <= 1'b1;
               end
            end
            S_WAIT: begin
               if (bus.div_done) begin
                  r_q   <= bus.div_quotient;
                  r_r   <= bus.div_remainder;
                  r_err <= 1'b0;
               end else if (w_tmo) begin
                  r_q   <= '0;
                  r_r   <= '0;
                  r_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP: begin
               r_cnt <= '0;
               r_ptr <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.gnt           = w_gnt;
   assign bus.rsp_valid     = w_rsp_vld;
   assign bus.rsp_quotient  = r_q;
   assign bus.rsp_remainder = r_r;
   assign bus.rsp_err       = r_err;
   assign bus.busy          = (r_state != S_IDLE);
   assign bus.div_start     = w_start;
   assign bus.div_dividend  = r_dvd;
   assign bus.div_divisor   = r_dvs;
endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: requester drivers, a 12-cycle divider model and a
// transaction-level reference that predicts grants, timing and results.
module tb_div_share_arbiter;
   localparam int N    = 2;
   localparam int W    = 4;
   localparam int TO   = 31;
   localparam int DLAT = 12;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   div_share_arbiter_if #(.NUM_REQ(N), .DW(W)) bus();

   div_share_arbiter #(.NUM_REQ(N), .DW(W), .TIMEOUT(TO)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit hang    = 1'b0;
   bit rmode   = 1'b0;
   int done_at = -1;
   logic [W-1:0] dq = '0, dr = '0;
   int left [N];
   bit pend [N];
   logic [W-1:0] a [N];
   logic [W-1:0] b [N];
   int own       = -1;
   int granted   = -1;
   bit resp_pend = 1'b0;
   int exp_ptr   = 0;
   int gnt_cyc   = -1;
   int rsp_cyc   = -1;
   logic [W-1:0] own_a = '0, own_b = '0, held_q = '0, held_r = '0;
   int glog [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Round-robin by definition: first requester at or after ptr, wrapping.
   function automatic int rr_ref(input int ptr, input logic [N-1:0] r);
      for (int k = 0; k < N; k++)
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   task automatic apply_req();
      for (int i = 0; i < N; i++) begin
         bus.req[i]               = pend[i];
         bus.dividend_in[i*W +: W] = a[i];
         bus.divisor_in[i*W +: W]  = b[i];
      end
   endtask

   task automatic new_ops(input int i);
      pend[i] = 1'b1;
      a[i]    = W'($urandom_range(0, 15));
      b[i]    = (rmode && $urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 15));
   endtask

   task automatic set_req(input int i, input logic [W-1:0] av, input logic [W-1:0] bv, input int n);
      pend[i] = 1'b1;
      a[i]    = av;
      b[i]    = bv;
      left[i] = n;
      apply_req();
   endtask

   task automatic drive();
      bus.div_done = 1'b0;
      if (cyc == done_at) begin
         bus.div_done      = 1'b1;
         bus.div_quotient  = dq;
         bus.div_remainder = dr;
      end else if (own < 0 && $urandom_range(0, 3) == 0) begin
         bus.div_done      = 1'b1;
         bus.div_quotient  = W'($urandom);
         bus.div_remainder = W'($urandom);
      end
      if (granted >= 0) begin
         left[granted]--;
         if (left[granted] > 0 && (!rmode || $urandom_range(0, 1) == 1)) new_ops(granted);
         else pend[granted] = 1'b0;
      end
      if (rmode) begin
         for (int i = 0; i < N; i++) begin
            if (i != granted) begin
               if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
               else if (!pend[i] && left[i] > 0 && $urandom_range(0, 2) == 0) new_ops(i);
            end
         end
      end
      apply_req();
   endtask

   task automatic step();
      logic [N-1:0] rq, e_gnt, e_rsp;
      logic e_busy, e_start, e_err;
      rq = bus.req;
      @(posedge clk);
      #1;
      cyc++;
      granted = -1;
      if (reset) begin
         chk("rst_gnt",   bus.gnt, 0);
         chk("rst_rsp",   bus.rsp_valid, 0);
         chk("rst_busy",  bus.busy, 0);
         chk("rst_start", bus.div_start, 0);
         chk("rst_err",   bus.rsp_err, 0);
         chk("rst_q",     bus.rsp_quotient, 0);
         chk("rst_r",     bus.rsp_remainder, 0);
         chk("rst_dvd",   bus.div_dividend, 0);
         chk("rst_dvs",   bus.div_divisor, 0);
         own = -1; resp_pend = 1'b0; exp_ptr = 0; held_q = '0; held_r = '0;
      end else begin
         e_gnt = '0; e_rsp = '0; e_busy = 1'b1;
         if (own < 0) begin
            granted = rr_ref(exp_ptr, rq);
            if (granted >= 0) begin
               own = granted; own_a = a[granted]; own_b = b[granted];
               gnt_cyc = cyc; e_gnt = oh(granted); glog.push_back(granted);
               rsp_cyc = (own_b == 0) ? cyc + 1 : (hang ? cyc + TO + 1 : cyc + DLAT + 1);
            end else begin
               e_busy = 1'b0;
            end
         end else if (resp_pend) begin
            own = -1; resp_pend = 1'b0; e_busy = 1'b0;
         end else if (cyc == rsp_cyc) begin
            e_rsp = oh(own); resp_pend = 1'b1; exp_ptr = (own + 1) % N;
            if (own_b == 0) begin
               held_q = '1; held_r = own_a; e_err = 1'b1;
            end else if (hang) begin
               held_q = '0; held_r = '0; e_err = 1'b1;
            end else begin
               held_q = own_a / own_b; held_r = own_a % own_b; e_err = 1'b0;
            end
            chk("rsp_err", bus.rsp_err, e_err);
         end
         e_start = (own >= 0) && (cyc == gnt_cyc) && (own_b != 0);
         chk("gnt",       bus.gnt, e_gnt);
         chk("rsp_valid", bus.rsp_valid, e_rsp);
         chk("busy",      bus.busy, e_busy);
         chk("div_start", bus.div_start, e_start);
         chk("rsp_q",     bus.rsp_quotient, held_q);
         chk("rsp_r",     bus.rsp_remainder, held_r);
         if (own >= 0) begin
            chk("div_dvd", bus.div_dividend, own_a);
            chk("div_dvs", bus.div_divisor, own_b);
         end
         if (bus.div_start && !hang && own_b != 0) begin
            done_at = cyc + DLAT; dq = own_a / own_b; dr = own_a % own_b;
         end
      end
      drive();
   endtask

   function automatic bit any_work();
      for (int i = 0; i < N; i++) if (pend[i] || left[i] > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic run(input string tag, input int maxc);
      int k;
      k = 0;
      while (k < maxc && (own >= 0 || resp_pend || any_work())) begin
         step();
         k++;
      end
      chk({tag, "_drain"}, (own >= 0 || resp_pend || any_work()) ? 1 : 0, 0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; left[i] = 0; end
      apply_req();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int k;
      bus.req = '0; bus.dividend_in = '0; bus.divisor_in = '0;
      bus.div_done = 1'b0; bus.div_quotient = '0; bus.div_remainder = '0;
      for (int i = 0; i < N; i++) begin left[i] = 0; pend[i] = 1'b0; a[i] = '0; b[i] = '0; end

      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;

      set_req(0, 4'd13, 4'd4, 1);
      run("single", 100);

      do_reset();
      glog.delete();
      set_req(0, 4'd15, 4'd2, 1);
      set_req(1, 4'd9, 4'd3, 1);
      run("contend", 100);
      chk("contend_n", glog.size(), 2);
      for (int i = 0; i < 2 && i < glog.size(); i++) chk("contend_order", glog[i], i);

      do_reset();
      glog.delete();
      set_req(0, W'($urandom_range(0, 15)), W'($urandom_range(1, 15)), 3);
      set_req(1, W'($urandom_range(0, 15)), W'($urandom_range(1, 15)), 3);
      run("fair", 200);
      chk("fair_n", glog.size(), 6);
      for (int i = 0; i < 6 && i < glog.size(); i++) chk("fair_order", glog[i], i % 2);

      set_req(1, 4'd10, 4'd0, 1);
      run("div0", 20);

      hang = 1'b1;
      set_req(0, 4'd9, 4'd2, 1);
      run("timeout", 100);
      hang = 1'b0;

      set_req(0, 4'd7, 4'd2, 1);
      k = 0;
      while (!(own >= 0 && cyc == gnt_cyc + 5) && k < 50) begin step(); k++; end
      chk("rstwait_reach", (own >= 0) ? 1 : 0, 1);
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; left[i] = 0; end
      apply_req();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (15) step();
      chk("stale_q", bus.rsp_quotient, 0);

      do_reset();
      rmode = 1'b1;
      for (int i = 0; i < N; i++) left[i] = $urandom_range(8, 14);
      run("random", 4000);
      rmode = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
